// File: rtl/multi_master_cmd_config_if.sv
// Button/switch inputs and per-master command buses of the command configurator.
// The board (or bench) drives through master; the configurator uses slave.
interface multi_master_cmd_config_if #(
    parameter int MASTER_NUM = 2,
    parameter int SLAVE_LEN  = 2,
    parameter int ADDR_LEN   = 12,
    parameter int DATA_LEN   = 8
);
    logic                               btn_next;
    logic                               btn_inc;
    logic                               btn_dec;
    logic [MASTER_NUM-1:0]              btn_trig;
    logic [MASTER_NUM-1:0]              rw_switch;
    logic                               mode_switch;
    logic [ADDR_LEN-1:0]                switch_array;
    logic [MASTER_NUM-1:0]              read;
    logic [MASTER_NUM-1:0]              write;
    logic [MASTER_NUM*SLAVE_LEN-1:0]    slave_bus;
    logic [MASTER_NUM*ADDR_LEN-1:0]     addr_bus;
    logic [MASTER_NUM*DATA_LEN-1:0]     data_bus;
    logic [MASTER_NUM*(ADDR_LEN+1)-1:0] burst_bus;
    logic [MASTER_NUM-1:0]              cfg_commit;
    logic [15:0]                        disp_val;

    modport master (
        output btn_next, btn_inc, btn_dec, btn_trig, rw_switch, mode_switch, switch_array,
        input  read, write, slave_bus, addr_bus, data_bus, burst_bus, cfg_commit, disp_val
    );

    modport slave (
        input  btn_next, btn_inc, btn_dec, btn_trig, rw_switch, mode_switch, switch_array,
        output read, write, slave_bus, addr_bus, data_bus, burst_bus, cfg_commit, disp_val
    );
endinterface

// File: rtl/multi_master_cmd_config.sv
// Button-driven configurator: builds a staged transaction, commits it to one
// master's shadow registers, and issues one-cycle read/write strobes in run mode.
module multi_master_cmd_config #(
    parameter int MASTER_NUM = 2,
    parameter int SLAVE_LEN  = 2,
    parameter int SLAVE_NUM  = 3,
    parameter int ADDR_LEN   = 12,
    parameter int DATA_LEN   = 8,
    parameter int BURST_MAX  = 4095
) (
    input logic                     clk,
    input logic                     reset,
    multi_master_cmd_config_if.slave bus
);
    localparam int IDX_W     = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
    localparam int BURST_LEN = ADDR_LEN + 1;

    localparam logic [IDX_W-1:0]     IDX_TOP   = IDX_W'(MASTER_NUM - 1);
    localparam logic [SLAVE_LEN-1:0] SLAVE_ONE = SLAVE_LEN'(1);
    localparam logic [SLAVE_LEN-1:0] SLAVE_TOP = SLAVE_LEN'(SLAVE_NUM);
    localparam logic [BURST_LEN-1:0] BURST_ONE = BURST_LEN'(1);
    localparam logic [BURST_LEN-1:0] BURST_TOP = BURST_LEN'(BURST_MAX);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SEL_MASTER = 3'd1,
        SEL_SLAVE  = 3'd2,
        SEL_ADDR   = 3'd3,
        SEL_DATA   = 3'd4,
        SEL_BURST  = 3'd5,
        CONFIRM    = 3'd6
    } state_t;

    state_t                state_reg;
    logic [IDX_W-1:0]      stg_idx_reg;
    logic [SLAVE_LEN-1:0]  stg_slave_reg;
    logic [ADDR_LEN-1:0]   stg_addr_reg;
    logic [DATA_LEN-1:0]   stg_data_reg;
    logic [BURST_LEN-1:0]  stg_burst_reg;
    logic                  next_q_reg, inc_q_reg, dec_q_reg;
    logic [MASTER_NUM-1:0] trig_q_reg;
    logic [MASTER_NUM-1:0] cfg_commit_reg, read_reg, write_reg;
    logic [MASTER_NUM-1:0] commit_sel;
    logic [11:0]           disp_low;

    // Edge detection with fixed priority next > inc > dec; run mode masks all config edges.
    logic ev_next, ev_inc, ev_dec, cfg_next, cfg_inc, cfg_dec, cfg_any, do_commit;
    logic [MASTER_NUM-1:0] ev_trig;
    assign ev_next   = bus.btn_next & ~next_q_reg;
    assign ev_inc    = bus.btn_inc  & ~inc_q_reg;
    assign ev_dec    = bus.btn_dec  & ~dec_q_reg;
    assign ev_trig   = bus.btn_trig & ~trig_q_reg;
    assign cfg_next  = ev_next & ~bus.mode_switch;
    assign cfg_inc   = ev_inc & ~ev_next & ~bus.mode_switch;
    assign cfg_dec   = ev_dec & ~ev_inc & ~ev_next & ~bus.mode_switch;
    assign cfg_any   = cfg_next | cfg_inc | cfg_dec;
    assign do_commit = (state_reg == CONFIRM) && cfg_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            stg_idx_reg    <= '0;
            stg_slave_reg  <= SLAVE_ONE;
            stg_addr_reg   <= '0;
            stg_data_reg   <= '0;
            stg_burst_reg  <= BURST_ONE;
            next_q_reg     <= 1'b1;
            inc_q_reg      <= 1'b1;
            dec_q_reg      <= 1'b1;
            trig_q_reg     <= '1;
            cfg_commit_reg <= '0;
            read_reg       <= '0;
            write_reg      <= '0;
        end else begin
            next_q_reg     <= bus.btn_next;
            inc_q_reg      <= bus.btn_inc;
            dec_q_reg      <= bus.btn_dec;
            trig_q_reg     <= bus.btn_trig;
            cfg_commit_reg <= commit_sel;
            read_reg       <= {MASTER_NUM{bus.mode_switch}} & ev_trig & bus.rw_switch;
            write_reg      <= {MASTER_NUM{bus.mode_switch}} & ev_trig & ~bus.rw_switch;
            if (bus.mode_switch || (state_reg == IDLE && cfg_any)) begin
                state_reg     <= bus.mode_switch ? IDLE : SEL_MASTER;
                stg_idx_reg   <= '0;
                stg_slave_reg <= SLAVE_ONE;
                stg_addr_reg  <= '0;
                stg_data_reg  <= '0;
                stg_burst_reg <= BURST_ONE;
            end else begin
                case (state_reg)
                    SEL_MASTER: begin
                        if (cfg_next)     state_reg   <= SEL_SLAVE;
                        else if (cfg_inc) stg_idx_reg <= (stg_idx_reg == IDX_TOP) ? '0 : stg_idx_reg + 1'b1;
                        else if (cfg_dec) stg_idx_reg <= (stg_idx_reg == '0) ? IDX_TOP : stg_idx_reg - 1'b1;
                    end
                    SEL_SLAVE: begin
                        if (cfg_next)     state_reg     <= SEL_ADDR;
                        else if (cfg_inc) stg_slave_reg <= (stg_slave_reg == SLAVE_TOP) ? SLAVE_ONE : stg_slave_reg + 1'b1;
                        else if (cfg_dec) stg_slave_reg <= (stg_slave_reg == SLAVE_ONE) ? SLAVE_TOP : stg_slave_reg - 1'b1;
                    end
                    SEL_ADDR: if (cfg_next) begin
                        stg_addr_reg <= bus.switch_array;
                        state_reg    <= SEL_DATA;
                    end
                    SEL_DATA: if (cfg_next) begin
                        stg_data_reg <= bus.switch_array[DATA_LEN-1:0];
                        state_reg    <= SEL_BURST;
                    end
                    SEL_BURST: begin
                        if (cfg_next)     state_reg     <= CONFIRM;
                        else if (cfg_inc) stg_burst_reg <= (stg_burst_reg == BURST_TOP) ? BURST_ONE : stg_burst_reg + 1'b1;
                        else if (cfg_dec) stg_burst_reg <= (stg_burst_reg == BURST_ONE) ? BURST_TOP : stg_burst_reg - 1'b1;
                    end
                    CONFIRM: if (cfg_next || cfg_dec) state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Per-master shadow registers; only the selected master loads on commit.
    generate
        for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_master
            logic [SLAVE_LEN-1:0] slave_sh_reg;
            logic [ADDR_LEN-1:0]  addr_sh_reg;
            logic [DATA_LEN-1:0]  data_sh_reg;
            logic [BURST_LEN-1:0] burst_sh_reg;

            assign commit_sel[gi] = do_commit && (stg_idx_reg == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    slave_sh_reg <= SLAVE_ONE;
                    addr_sh_reg  <= '0;
                    data_sh_reg  <= '0;
                    burst_sh_reg <= BURST_ONE;
                end else if (commit_sel[gi]) begin
                    slave_sh_reg <= stg_slave_reg;
                    addr_sh_reg  <= stg_addr_reg;
                    data_sh_reg  <= stg_data_reg;
                    burst_sh_reg <= stg_burst_reg;
                end
            end

            assign bus.slave_bus[gi*SLAVE_LEN +: SLAVE_LEN] = slave_sh_reg;
            assign bus.addr_bus[gi*ADDR_LEN +: ADDR_LEN]    = addr_sh_reg;
            assign bus.data_bus[gi*DATA_LEN +: DATA_LEN]    = data_sh_reg;
            assign bus.burst_bus[gi*BURST_LEN +: BURST_LEN] = burst_sh_reg;
        end
    endgenerate

    // Display follows the live switches in the entry states so the user sees what next will latch.
    always_comb begin
        disp_low = '0;
        case (state_reg)
            SEL_MASTER:         disp_low = 12'(stg_idx_reg) + 12'd1;
            SEL_SLAVE:          disp_low = 12'(stg_slave_reg);
            SEL_ADDR:           disp_low = 12'(bus.switch_array);
            SEL_DATA:           disp_low = 12'(bus.switch_array[DATA_LEN-1:0]);
            SEL_BURST, CONFIRM: disp_low = 12'(stg_burst_reg);
            default:            disp_low = '0;
        endcase
    end

    assign bus.disp_val   = bus.mode_switch ? 16'h0000 : {1'b0, state_reg, disp_low};
    assign bus.cfg_commit = cfg_commit_reg;
    assign bus.read       = read_reg;
    assign bus.write      = write_reg;
endmodule
